// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MIPS data-memory path:
//                access-size encoding, memory-access FSM states, the
//                full-word byte-enable constant and the alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Access size as presented on req_size; value 3 is reserved and is
  // handled as a word access wherever the size is decoded.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } mau_state_t;

  localparam logic [3:0] BYTEEN_WORD = 4'hF;

  // Natural-alignment test: bytes never misalign, halves need addr[0]=0,
  // words (and the reserved size) need addr[1:0]=0.
  function automatic logic mau_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    if (size == SZ_BYTE)      return 1'b0;
    else if (size == SZ_HALF) return addr_lo[0];
    else                      return (addr_lo != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Bundles the core-side request/response signals and the
//                Avalon-MM data-bus signals of the memory access unit.
//                modport slave  : the memory access unit itself
//                modport master : its environment (core + memory model)
//  Ports       : req_read/req_write/req_size/req_signed/req_addr/req_wdata,
//                stall/rd_valid/rd_data/err,
//                avm_address/avm_read/avm_write/avm_byteenable/
//                avm_writedata/avm_readdata/avm_waitrequest
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_read;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              err;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport slave (
    input  req_read, req_write, req_size, req_signed, req_addr, req_wdata,
    input  avm_readdata, avm_waitrequest,
    output stall, rd_valid, rd_data, err,
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
  );

  modport master (
    output req_read, req_write, req_size, req_signed, req_addr, req_wdata,
    output avm_readdata, avm_waitrequest,
    input  stall, rd_valid, rd_data, err,
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
  );
endinterface
`default_nettype wire

// File: rtl/byte_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_align
//  Description : Combinational lane steering for the 32-bit little-endian
//                data bus: byte enables, store-data replication, and load
//                extraction with sign/zero extension.
//  Ports       : size, addr_lo, sign_ext, wdata, rdata (in)
//                byteen, wdata_rep, rdata_ext (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteen,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Half accesses select their lane pair with addr[1] only; addr[0] is
  // ignored here (alignment policy lives in the FSM).
  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    byteen    = BYTEEN_WORD;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (size)
      SZ_BYTE: begin
        byteen    = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign_ext & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        byteen    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign_ext & lane_h[15]}}, lane_h};
      end
      default: ; // word and reserved size: full lanes, no extension
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Data-memory responder. Turns MemRead/MemWrite requests into
//                single Avalon-MM transactions with waitrequest handshake,
//                steers byte lanes, extends load data, and stalls the
//                pipeline until each transaction completes.
//  Ports       : clk, reset (async, active-high)
//                bus : mem_access_unit_if.slave (request, response, Avalon)
//  Option      : MEM_ALIGN_CHECK_EN - misaligned half/word accesses skip the
//                bus cycle and pulse err instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32  // fixed at 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_access_unit_if.slave      bus
);

  mau_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_read_q, is_read_d;
  logic              err_q, err_d;
  logic [31:0]       rd_data_q, rd_data_d;

  logic        req_any;
  logic        misalign;
  logic        in_bus;
  logic        accepting;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign req_any   = bus.req_read | bus.req_write;
  assign in_bus    = (state_q == BUS);
  assign accepting = (state_q == IDLE) || (state_q == RESP);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mau_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // Lane logic works purely from the captured request so bus outputs stay
  // stable while waitrequest holds the transaction.
  byte_lane_align u_align (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .sign_ext  (signed_q),
    .wdata     (wdata_q[31:0]),
    .rdata     (bus.avm_readdata),
    .byteen    (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    signed_d  = signed_q;
    wdata_d   = wdata_q;
    is_read_d = is_read_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
        if (req_any) begin
          addr_d    = bus.req_addr;
          size_d    = bus.req_size;
          signed_d  = bus.req_signed;
          wdata_d   = bus.req_wdata;
          is_read_d = bus.req_read;        // read wins when both are raised
          err_d     = misalign;
          state_d   = misalign ? RESP : BUS;
        end
      end
      BUS: begin
        if (!bus.avm_waitrequest) begin
          if (is_read_q) begin
            rd_data_d = lane_rdata;
            state_d   = RESP;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      wdata_q   <= '0;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      wdata_q   <= wdata_d;
      is_read_q <= is_read_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Bus outputs decode straight from state so an async reset drops them
  // immediately; outside BUS they are all zero.
  assign bus.avm_read       = in_bus & is_read_q;
  assign bus.avm_write      = in_bus & ~is_read_q;
  assign bus.avm_address    = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.avm_byteenable = in_bus ? lane_be : 4'b0000;
  assign bus.avm_writedata  = in_bus ? lane_wdata : 32'h0;

  // The request cycle itself stalls, hence the combinational req term.
  assign bus.stall    = (accepting & req_any) | in_bus;
  assign bus.rd_valid = (state_q == RESP) & ~err_q;
  assign bus.rd_data  = rd_data_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign bus.err = (state_q == RESP) & err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit: directed vector
//                table, randomized transactions against a behavioural
//                model, plus back-to-back and reset-abort sequences.
//  Option      : MEM_ALIGN_CHECK_EN changes expectations for misaligned
//                accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---- behavioural model: plain arithmetic on the lane rules ----
  function automatic logic [3:0] m_be(input int sz, input int lo);
    if (sz == 0) return 4'(1 << lo);
    if (sz == 1) return (lo >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] w);
    if (sz == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_rdata(input int sz, input int lo, input logic sgn,
                                          input logic [31:0] r);
    logic [31:0] v;
    if (sz == 0) begin
      v = (r >> (8 * lo)) & 32'hFF;
      if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (r >> (16 * (lo / 2))) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  function automatic logic m_misaligned(input int sz, input int lo);
    if (!ALIGN_CHK) return 1'b0;
    if (sz == 0) return 1'b0;
    if (sz == 1) return (lo % 2) != 0;
    return lo != 0;
  endfunction

  // Runs one transaction from IDLE; called just after a rising edge.
  task automatic run_txn(input string tag, input logic rd, input logic wr,
                         input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits,
                         input logic exp_err, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata);
    logic is_rd;
    is_rd = rd;
    bus.req_read        = rd;
    bus.req_write       = wr;
    bus.req_size        = size;
    bus.req_signed      = sgn;
    bus.req_addr        = addr;
    bus.req_wdata       = wdata;
    bus.avm_readdata    = rdata;
    bus.avm_waitrequest = (waits > 0);
    @(negedge clk);
    chk({tag, ".req_stall"}, 32'(bus.stall), 32'd1);
    chk({tag, ".req_strobes"}, 32'({bus.avm_read, bus.avm_write}), 32'd0);
    next_cycle();
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    if (exp_err) begin
      @(negedge clk);
      chk({tag, ".err"}, 32'(bus.err), 32'd1);
      chk({tag, ".err_rd_valid"}, 32'(bus.rd_valid), 32'd0);
      chk({tag, ".err_strobes"}, 32'({bus.avm_read, bus.avm_write}), 32'd0);
      chk({tag, ".err_stall"}, 32'(bus.stall), 32'd0);
      next_cycle();
    end else begin
      for (int k = 1; k <= waits + 1; k++) begin
        bus.avm_waitrequest = (k <= waits);
        @(negedge clk);
        chk($sformatf("%s.c%0d.avm_read", tag, k), 32'(bus.avm_read), 32'(is_rd));
        chk($sformatf("%s.c%0d.avm_write", tag, k), 32'(bus.avm_write), 32'(!is_rd));
        chk($sformatf("%s.c%0d.address", tag, k), bus.avm_address, exp_addr);
        chk($sformatf("%s.c%0d.byteen", tag, k), 32'(bus.avm_byteenable), 32'(exp_be));
        if (!is_rd)
          chk($sformatf("%s.c%0d.writedata", tag, k), bus.avm_writedata, exp_wdata);
        chk($sformatf("%s.c%0d.stall", tag, k), 32'(bus.stall), 32'd1);
        chk($sformatf("%s.c%0d.rd_valid", tag, k), 32'(bus.rd_valid), 32'd0);
        next_cycle();
      end
      bus.avm_waitrequest = 1'b0;
      @(negedge clk);
      chk({tag, ".done_rd_valid"}, 32'(bus.rd_valid), 32'(is_rd));
      if (is_rd) chk({tag, ".rd_data"}, bus.rd_data, exp_rdata);
      chk({tag, ".done_stall"}, 32'(bus.stall), 32'd0);
      chk({tag, ".done_strobes"}, 32'({bus.avm_read, bus.avm_write}), 32'd0);
      chk({tag, ".done_err"}, 32'(bus.err), 32'd0);
      next_cycle();
    end
  endtask

  initial begin
    logic        rd, wr, sgn;
    logic [1:0]  sz;
    logic [31:0] a, wd, rdat;
    int          w, mode;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req_read = 1'b0;  bus.req_write = 1'b0;
    bus.req_size = 2'd0;  bus.req_signed = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.avm_readdata = 32'h0; bus.avm_waitrequest = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.stall", 32'(bus.stall), 32'd0);
    chk("rst.rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst.rd_data", bus.rd_data, 32'd0);
    chk("rst.strobes", 32'({bus.avm_read, bus.avm_write}), 32'd0);
    chk("rst.address", bus.avm_address, 32'd0);
    chk("rst.byteen", 32'(bus.avm_byteenable), 32'd0);
    chk("rst.writedata", bus.avm_writedata, 32'd0);
    chk("rst.err", 32'(bus.err), 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // ---- directed vector table ----
    //          rd    wr    size  sgn   addr        wdata         rdata         w  err        exp_addr    be     exp_wdata     exp_rdata
    vecs[0] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h100,  32'hDEADBEEF, 32'h0,        0, 1'b0,      32'h100, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h103,  32'h000000AB, 32'h0,        0, 1'b0,      32'h100, 4'h8, 32'hABABABAB, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h102,  32'h0,        32'h00800000, 0, 1'b0,      32'h100, 4'h4, 32'h0,        32'hFFFFFF80};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h102,  32'h0,        32'h00800000, 0, 1'b0,      32'h100, 4'h4, 32'h0,        32'h00000080};
    vecs[4] = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h102,  32'h0,        32'h80010000, 0, 1'b0,      32'h100, 4'hC, 32'h0,        32'hFFFF8001};
    vecs[5] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h200,  32'h0,        32'h12345678, 3, 1'b0,      32'h200, 4'hF, 32'h0,        32'h12345678};
    vecs[6] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h106,  32'hFFFF1234, 32'h0,        1, 1'b0,      32'h104, 4'hC, 32'h12341234, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h100,  32'h0,        32'h0000F00D, 0, 1'b0,      32'h100, 4'h3, 32'h0,        32'h0000F00D};
    vecs[8] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h300,  32'h11111111, 32'hCAFEF00D, 2, 1'b0,      32'h300, 4'hF, 32'h0,        32'hCAFEF00D};
    vecs[9] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h102,  32'h0,        32'hA5A5_5A5A, 0, ALIGN_CHK, 32'h100, 4'hF, 32'h0,       32'hA5A55A5A};

    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].sgn,
              vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].waits,
              vecs[i].exp_err, vecs[i].exp_addr, vecs[i].exp_be,
              vecs[i].exp_wdata, vecs[i].exp_rdata);
    end

    // ---- back-to-back: new store accepted in the load's RESP cycle ----
    bus.req_read = 1'b1; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    bus.req_addr = 32'h500; bus.avm_readdata = 32'h0BADCAFE; bus.avm_waitrequest = 1'b0;
    next_cycle();
    bus.req_read = 1'b0;
    @(negedge clk);
    chk("b2b.avm_read", 32'(bus.avm_read), 32'd1);
    next_cycle();
    bus.req_write = 1'b1; bus.req_addr = 32'h504; bus.req_wdata = 32'h55AA55AA;
    @(negedge clk);
    chk("b2b.rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("b2b.rd_data", bus.rd_data, 32'h0BADCAFE);
    chk("b2b.resp_stall", 32'(bus.stall), 32'd1);
    next_cycle();
    bus.req_write = 1'b0;
    @(negedge clk);
    chk("b2b.avm_write", 32'(bus.avm_write), 32'd1);
    chk("b2b.address", bus.avm_address, 32'h504);
    chk("b2b.writedata", bus.avm_writedata, 32'h55AA55AA);
    chk("b2b.rd_valid_off", 32'(bus.rd_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("b2b.idle_stall", 32'(bus.stall), 32'd0);
    next_cycle();

    // ---- reset during BUS aborts the load ----
    bus.req_read = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'h400;
    bus.avm_waitrequest = 1'b1;
    next_cycle();
    bus.req_read = 1'b0;
    @(negedge clk);
    chk("rstbus.avm_read_before", 32'(bus.avm_read), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstbus.avm_read", 32'(bus.avm_read), 32'd0);
    chk("rstbus.stall", 32'(bus.stall), 32'd0);
    chk("rstbus.address", bus.avm_address, 32'd0);
    next_cycle();
    reset = 1'b0;
    bus.avm_waitrequest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rstbus.after%0d.rd_valid", k), 32'(bus.rd_valid), 32'd0);
      chk($sformatf("rstbus.after%0d.busy", k), 32'({bus.stall, bus.avm_read, bus.avm_write}), 32'd0);
      next_cycle();
    end

    // ---- randomized transactions against the model ----
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      rd   = (mode != 1);
      wr   = (mode != 0);
      sz   = 2'($urandom_range(0, 3));
      sgn  = 1'($urandom_range(0, 1));
      a    = $urandom & 32'h0000_FFFF;
      wd   = $urandom;
      rdat = $urandom;
      w    = $urandom_range(0, 3);
      run_txn($sformatf("rnd%0d", i), rd, wr, sz, sgn, a, wd, rdat, w,
              m_misaligned(int'(sz), int'(a % 4)), a - (a % 4),
              m_be(int'(sz), int'(a % 4)), m_wdata(int'(sz), wd),
              m_rdata(int'(sz), int'(a % 4), sgn, rdat));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory responder for the MIPS core. It executes the MemRead/MemWrite requests raised by the control unit as single transactions on the Avalon-MM data bus, using a waitrequest handshake. It steers byte lanes for byte, halfword and word accesses and sign- or zero-extends load data. It holds the pipeline in a stall until each transaction completes.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, bus data width (fixed at 32; other values unsupported)

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- req_read  in  1  load request (MemRead)
- req_write  in  1  store request (MemWrite)
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- req_signed  in  1  sign-extend load (LB/LH=1, LBU/LHU=0)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  hold pipeline
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  32  extended load result
- avm_address  out  ADDR_W  word-aligned address (bits [1:0]=0)
- avm_read, avm_write  out  1  bus strobes
- avm_byteenable  out  4  lane enables, little-endian
- avm_writedata  out  32  lane-replicated store data
- avm_readdata  in  32  bus read data
- avm_waitrequest  in  1  slave not ready
- err  out  1  misalignment pulse (only with MEM_ALIGN_CHECK_EN; tied 0 otherwise)

## Operation
- FSM states: IDLE, BUS, RESP. Reset state is IDLE.
- IDLE/RESP:
  - On req_read|req_write, capture addr/size/signed/wdata/direction and go to BUS.
  - If both requests are high, the read wins.
- BUS:
  - Drive strobe, address, byteenable and writedata from the captured registers.
  - Stay in BUS while avm_waitrequest=1; all bus outputs are held stable.
  - On waitrequest=0, a write goes to IDLE. A read latches the extracted data and goes to RESP.
- RESP: rd_valid=1 for exactly one cycle. A new request may be accepted in the same cycle.
- stall = ((IDLE|RESP) & (req_read|req_write)) | BUS. This is combinational, so the request cycle itself stalls.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction: shift readdata right by addr[1:0]*8 for byte, or addr[1]*16 for half. Then extend to 32 bits using req_signed.
- Reset values: stall=0, rd_valid=0, rd_data=0, strobes=0, avm_address=0, byteenable=0, writedata=0, err=0.
- Reset mid-transaction aborts immediately: strobes drop asynchronously and no rd_valid is produced.

## Timing
- Zero-wait read: request at cycle 0 (stall=1); avm_read=1 at cycle 1; rd_valid=1 and stall=0 at cycle 2.
- Zero-wait write: request at cycle 0; avm_write=1 at cycle 1; IDLE with stall=0 at cycle 2.
- Each waitrequest cycle adds one cycle of latency. No timeout.
- A back-to-back request accepted in RESP issues its strobe on the next cycle.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no bus cycle.
  - The FSM goes to RESP with err=1 and rd_valid=0 for one cycle; stall clears that cycle.
- Undefined:
  - Misaligned low address bits are ignored: half uses addr[1] only, word uses neither.
  - err is constant 0.

## Structure
- Shared package mips_pkg holds:
  - enum mem_size_t (SZ_BYTE, SZ_HALF, SZ_WORD)
  - enum mau_state_t (IDLE, BUS, RESP)
  - constant BYTEEN_WORD = 4'hF
- One combinational sub-module, byte_lane_align: byteenable and writedata generation, plus load extraction and extension.

## Test plan
- Write sequence:
  - SW 0xDEADBEEF to 0x100 with zero wait → avm_write at cycle 1, address 0x100, byteenable 0xF, stall high for cycles 0–1.
  - SB 0x000000AB to 0x103 → byteenable 0x8, writedata 0xABABABAB.
- Read sequence:
  - LB from 0x102, readdata 0x00800000, signed → rd_data 0xFFFFFF80.
  - LBU from 0x102, same readdata → 0x00000080.
  - LH from 0x102, readdata 0x80010000, signed → rd_data 0xFFFF8001.
- LW with waitrequest held for 3 cycles → strobe and address stable throughout, rd_valid at cycle 5, stall low at cycle 5.
- req_read and req_write both high → read transaction only; avm_write never asserts.
- Reset asserted during BUS → strobes and stall go 0 immediately; after release the FSM is in IDLE with no rd_valid.
- With MEM_ALIGN_CHECK_EN, LW at 0x102 → no strobe, err pulse at cycle 1, rd_valid stays 0. Without the macro → read at 0x100.
